// File: rtl/usiq_if.sv
// AXI-stream style output bus of the upstream I/Q packer, toward the FIFO write port.
// Handshake: a word transfers on a posedge where out_tvalid && out_tready; once valid
// is raised, data/last/user hold steady and valid stays high until that transfer.
interface usiq_if;
  logic [23:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;
  logic [1:0]  out_tuser;

  modport master (output out_tdata, output out_tvalid, output out_tlast,
                  output out_tuser, input out_tready);
  modport slave  (input out_tdata, input out_tvalid, input out_tlast,
                  input out_tuser, output out_tready);
endinterface

// File: rtl/usiq_packer.sv
// Serialises parallel per-receiver I/Q sample instants into a framed 24-bit word stream,
// with one staging slot ahead of the active group and whole-instant drop on overrun.
module usiq_packer #(
  parameter int NR  = 4,
  parameter int SPP = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_strobe,
  input  logic [NR*48-1:0] rx_iq,
  input  logic [3:0]      nrx_active,
  usiq_if.master          m_axis,
  output logic [15:0]     drop_count,
  output logic            fsm_state
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [NR*48-1:0]  stage_q, stage_d;
  logic [NR*48-1:0]  sh_q, sh_d;
  logic              stage_full_q, stage_full_d;
  logic [3:0]        word_q, word_d;
  logic [7:0]        group_q, group_d;
  logic [3:0]        nr_act_q, nr_act_d;
  logic              overrun_q, overrun_d;
  logic              user1_q, user1_d;
  logic [15:0]       drop_q, drop_d;

  logic              accept, last_word, first_word, move, drop;
  logic [7:0]        group_next;
  logic [3:0]        nr_clamp;
  logic [4:0]        last_idx;
  logic [47:0]       sel;

  always_comb begin
    nr_clamp = nrx_active;
    if (nrx_active == 4'd0)
      nr_clamp = 4'd1;
    else if (nrx_active > 4'(NR))
      nr_clamp = 4'(NR);
    last_idx   = {nr_act_q, 1'b0} - 5'd1;
    last_word  = ({1'b0, word_q} == last_idx);
    first_word = (word_q == 4'd0) && (group_q == 8'd0);
    accept     = (state_q == SEND) && m_axis.out_tready;
    group_next = (group_q == 8'(SPP - 1)) ? 8'd0 : group_q + 8'd1;
    // The stage empties into the shift register either from IDLE or exactly when the
    // last word of the current group is accepted, which keeps back-to-back groups gapless.
    move       = stage_full_q && ((state_q == IDLE) || (accept && last_word));
    drop       = rx_strobe && stage_full_q && !move;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (move) state_d = SEND;
      SEND:    if (accept && last_word && !stage_full_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sel = '0;
    for (int k = 0; k < NR; k++)
      if (word_q[3:1] == 3'(k)) sel = sh_q[k*48 +: 48];
    m_axis.out_tvalid = (state_q == SEND);
    m_axis.out_tdata  = '0;
    if (state_q == SEND)
      m_axis.out_tdata = word_q[0] ? sel[23:0] : sel[47:24];
    m_axis.out_tlast  = (state_q == SEND) && last_word && (group_q == 8'(SPP - 1));
    m_axis.out_tuser  = {(state_q == SEND) && first_word && user1_q,
                         (state_q == SEND) && first_word};
    drop_count        = drop_q;
    fsm_state         = state_q;
  end

  always_comb begin
    stage_d      = stage_q;
    stage_full_d = stage_full_q;
    sh_d         = sh_q;
    word_d       = word_q;
    group_d      = group_q;
    nr_act_d     = nr_act_q;
    overrun_d    = overrun_q;
    user1_d      = user1_q;
    drop_d       = drop_q;
    if (accept) begin
      if (last_word) begin
        word_d  = 4'd0;
        group_d = group_next;
      end else begin
        word_d  = word_q + 4'd1;
      end
    end
    if (move) begin
      sh_d         = stage_q;
      stage_full_d = 1'b0;
      word_d       = 4'd0;
      // Packet header is frozen at load so tuser stays stable while the word is held;
      // drops after this point are reported on the following packet.
      if (group_d == 8'd0) begin
        nr_act_d  = nr_clamp;
        user1_d   = overrun_q;
        overrun_d = 1'b0;
      end
    end
    if (rx_strobe && !drop) begin
      stage_d      = rx_iq;
      stage_full_d = 1'b1;
    end
    if (drop) begin
      overrun_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      sh_q         <= '0;
      word_q       <= 4'd0;
      group_q      <= 8'd0;
      nr_act_q     <= 4'd1;
      overrun_q    <= 1'b0;
      user1_q      <= 1'b0;
      drop_q       <= 16'd0;
    end else begin
      stage_q      <= stage_d;
      stage_full_q <= stage_full_d;
      sh_q         <= sh_d;
      word_q       <= word_d;
      group_q      <= group_d;
      nr_act_q     <= nr_act_d;
      overrun_q    <= overrun_d;
      user1_q      <= user1_d;
      drop_q       <= drop_d;
    end
  end

endmodule
